divide_param: RTL and testbench

Parametrised sequential integer divider: DD_W-bit dividend by DV_W-bit divisor, quotient plus remainder. It uses one radix-2 shift/subtract iteration per clock, with a go/done handshake. It is the next generation of the divider datapath/controller pair: one clock domain, no gated clocks, selectable signed/unsigned mode, divide-by-zero reporting and an exposed present-state code for debug benches.

---
 rtl/divide_param_if.sv | 24 ++
 rtl/divide_param.sv | 161 ++++++++++++++++
 tb/tb_divide_param.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/divide_param_if.sv
// rtl/divide_param_if.sv - go/done handshake and operand/result bundle for divide_param
interface divide_param_if #(
  parameter int DD_W = 32,
  parameter int DV_W = 16
);
  logic            go;
  logic [DD_W-1:0] ddInput;
  logic [DV_W-1:0] dvInput;
  logic [DD_W-1:0] quotient;
  logic [DV_W-1:0] resto;
  logic            done;
  logic            div0;
  logic [1:0]      EstPresente;

  modport master (
    output go, ddInput, dvInput,
    input  quotient, resto, done, div0, EstPresente
  );

  modport slave (
    input  go, ddInput, dvInput,
    output quotient, resto, done, div0, EstPresente
  );
endinterface

// File: rtl/divide_param.sv
// rtl/divide_param.sv - radix-2 sequential signed/unsigned divider; DIV_REMAINDER_EN enables the remainder output
module divide_param #(
  parameter int DD_W   = 32,
  parameter int DV_W   = 16,
  parameter bit SIGNED = 1'b1
) (
  input logic            reloj,
  input logic            reset,
  divide_param_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(DD_W);
  localparam int PW    = DV_W + 1;

  state_t            state_q, state_d;
  logic [DD_W-1:0]   dd_q, dd_d;          // operand, then magnitude, then quotient bits shifted in
  logic [DV_W-1:0]   dv_q, dv_d;          // operand, then magnitude
  logic [DV_W:0]     p_q, p_d;            // partial remainder
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              negq_q, negq_d;      // quotient must be negated in FIX
  logic [DD_W-1:0]   quotient_q, quotient_d;
  logic              done_q, done_d;
  logic              div0_q, div0_d;
`ifdef DIV_REMAINDER_EN
  logic              negr_q, negr_d;      // remainder takes the dividend's sign
  logic [DV_W-1:0]   resto_q, resto_d;
`endif

  logic              dd_neg, dv_neg;
  logic [DV_W+1:0]   p_wide;
  logic [DV_W+1:0]   dv_ext;
  logic              ge;

  assign dd_neg = SIGNED && dd_q[DD_W-1];
  assign dv_neg = SIGNED && dv_q[DV_W-1];
  // Shift the next dividend bit into P; the top bit of the quotient register is that bit
  assign p_wide = {p_q, dd_q[DD_W-1]};
  assign dv_ext = {2'b00, dv_q};
  assign ge     = (p_wide >= dv_ext);

  // Next-state and datapath decisions for the four-state controller
  always_comb begin
    state_d    = state_q;
    dd_d       = dd_q;
    dv_d       = dv_q;
    p_d        = p_q;
    cnt_d      = cnt_q;
    negq_d     = negq_q;
    quotient_d = quotient_q;
    done_d     = done_q;
    div0_d     = div0_q;
`ifdef DIV_REMAINDER_EN
    negr_d     = negr_q;
    resto_d    = resto_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.go) begin
          dd_d    = bus.ddInput;
          dv_d    = bus.dvInput;
          div0_d  = 1'b0;
          done_d  = 1'b0;
          state_d = PREP;
        end
      end
      PREP: begin
        if (dv_q == '0) begin
          quotient_d = '1;
`ifdef DIV_REMAINDER_EN
          resto_d    = '0;
`endif
          div0_d     = 1'b1;
          done_d     = 1'b1;
          state_d    = IDLE;
        end else begin
          // Negating the most negative value yields its own pattern, which is the
          // correct magnitude when read as unsigned.
          dd_d    = dd_neg ? -dd_q : dd_q;
          dv_d    = dv_neg ? -dv_q : dv_q;
          negq_d  = dd_neg ^ dv_neg;
`ifdef DIV_REMAINDER_EN
          negr_d  = dd_neg;
`endif
          p_d     = '0;
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        p_d   = ge ? PW'(p_wide - dv_ext) : p_wide[DV_W:0];
        dd_d  = {dd_q[DD_W-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DD_W - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        quotient_d = negq_q ? -dd_q : dd_q;
`ifdef DIV_REMAINDER_EN
        resto_d    = negr_q ? -p_q[DV_W-1:0] : p_q[DV_W-1:0];
`endif
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over any pending go
  always_ff @(posedge reloj) begin
    if (reset) begin
      state_q    <= IDLE;
      dd_q       <= '0;
      dv_q       <= '0;
      p_q        <= '0;
      cnt_q      <= '0;
      negq_q     <= 1'b0;
      quotient_q <= '0;
      done_q     <= 1'b1;
      div0_q     <= 1'b0;
`ifdef DIV_REMAINDER_EN
      negr_q     <= 1'b0;
      resto_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      dd_q       <= dd_d;
      dv_q       <= dv_d;
      p_q        <= p_d;
      cnt_q      <= cnt_d;
      negq_q     <= negq_d;
      quotient_q <= quotient_d;
      done_q     <= done_d;
      div0_q     <= div0_d;
`ifdef DIV_REMAINDER_EN
      negr_q     <= negr_d;
      resto_q    <= resto_d;
`endif
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.done        = done_q;
  assign bus.div0        = div0_q;
  assign bus.EstPresente = state_q;
`ifdef DIV_REMAINDER_EN
  assign bus.resto       = resto_q;
`else
  assign bus.resto       = '0;
`endif

endmodule

// File: tb/tb_divide_param.sv
// tb/tb_divide_param.sv - directed self-checking bench for divide_param (signed and unsigned instances)
module tb_divide_param;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   busy;
  int   iter_n;
  logic [1:0] st [0:255];

  divide_param_if #(.DD_W(32), .DV_W(16)) bs ();
  divide_param_if #(.DD_W(32), .DV_W(16)) bu ();

  divide_param #(.DD_W(32), .DV_W(16), .SIGNED(1'b1)) u_dut (
    .reloj (clk),
    .reset (reset),
    .bus   (bs)
  );

  divide_param #(.DD_W(32), .DV_W(16), .SIGNED(1'b0)) u_dut_u (
    .reloj (clk),
    .reset (reset),
    .bus   (bu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] exp_r(input logic [15:0] r);
`ifdef DIV_REMAINDER_EN
    return r;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done first reads 1.
  task automatic run_s(input logic [31:0] dd, input logic [15:0] dv, input int pulse_at, output int nbusy);
    bs.go = 1'b1; bs.ddInput = dd; bs.dvInput = dv;
    @(negedge clk);
    bs.go = 1'b0; bs.ddInput = $urandom; bs.dvInput = 16'($urandom);
    nbusy = 0;
    while (bs.done !== 1'b1 && nbusy < 200) begin
      st[nbusy] = bs.EstPresente;
      nbusy++;
      bs.go = (nbusy == pulse_at);
      @(negedge clk);
    end
    bs.go = 1'b0;
  endtask

  task automatic run_u(input logic [31:0] dd, input logic [15:0] dv, output int nbusy);
    bu.go = 1'b1; bu.ddInput = dd; bu.dvInput = dv;
    @(negedge clk);
    bu.go = 1'b0;
    nbusy = 0;
    while (bu.done !== 1'b1 && nbusy < 200) begin
      nbusy++;
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1;
    bs.go = 1'b0; bs.ddInput = '0; bs.dvInput = '0;
    bu.go = 1'b0; bu.ddInput = '0; bu.dvInput = '0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_done", bs.done, 1'b1);
    check("rst_q", bs.quotient, 32'h0);
    check("rst_r", bs.resto, 16'h0);
    check("rst_div0", bs.div0, 1'b0);
    check("rst_state", bs.EstPresente, 2'd0);
    check("rst_u_done", bu.done, 1'b1);

    // 100 / 7 with latency and state trace
    run_s(32'd100, 16'd7, 0, busy);
    check("t1_busy", busy, 34);
    check("t1_st_prep", st[0], 2'd1);
    iter_n = 0;
    for (int i = 1; i <= 32; i++) if (st[i] == 2'd2) iter_n++;
    check("t1_iter_n", iter_n, 32);
    check("t1_st_fix", st[33], 2'd3);
    check("t1_st_idle", bs.EstPresente, 2'd0);
    check("t1_q", bs.quotient, 32'd14);
    check("t1_r", bs.resto, exp_r(16'd2));
    check("t1_div0", bs.div0, 1'b0);

    // back-to-back: -100 / 7 started the cycle done first reads 1
    run_s(-32'sd100, 16'd7, 0, busy);
    check("t2a_busy", busy, 34);
    check("t2a_q", bs.quotient, 32'hFFFF_FFF2);
    check("t2a_r", bs.resto, exp_r(16'hFFFE));
    run_s(32'd100, -16'sd7, 0, busy);
    check("t2b_q", bs.quotient, 32'hFFFF_FFF2);
    check("t2b_r", bs.resto, exp_r(16'd2));
    run_s(-32'sd100, -16'sd7, 0, busy);
    check("t2c_q", bs.quotient, 32'd14);
    check("t2c_r", bs.resto, exp_r(16'hFFFE));
    run_s(32'd7, -16'sd3, 0, busy);
    check("t2d_q", bs.quotient, 32'hFFFF_FFFE);
    check("t2d_r", bs.resto, exp_r(16'd1));
    run_s(32'd100, 16'h8000, 0, busy);
    check("t2e_q", bs.quotient, 32'd0);
    check("t2e_r", bs.resto, exp_r(16'd100));

    // divide by zero, then a normal op clears div0
    run_s(32'd100, 16'd0, 0, busy);
    check("t3_busy", busy, 1);
    check("t3_div0", bs.div0, 1'b1);
    check("t3_q", bs.quotient, 32'hFFFF_FFFF);
    check("t3_r", bs.resto, 16'h0);
    run_s(32'd9, 16'd3, 0, busy);
    check("t3b_div0", bs.div0, 1'b0);
    check("t3b_q", bs.quotient, 32'd3);
    check("t3b_r", bs.resto, 16'h0);

    // overflow case with a stray go pulse mid-operation
    run_s(32'h8000_0000, 16'hFFFF, 10, busy);
    check("t4_busy", busy, 34);
    check("t4_q", bs.quotient, 32'h8000_0000);
    check("t4_r", bs.resto, 16'h0);
    check("t4_st", bs.EstPresente, 2'd0);

    // reset in the middle of 1000 / 3
    bs.go = 1'b1; bs.ddInput = 32'd1000; bs.dvInput = 16'd3;
    @(negedge clk);
    bs.go = 1'b0;
    for (int i = 0; i < 9; i++) @(negedge clk);
    check("t5_busy_before", bs.done, 1'b0);
    reset = 1'b1;
    bs.go = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bs.go = 1'b0;
    check("t5_done", bs.done, 1'b1);
    check("t5_q", bs.quotient, 32'h0);
    check("t5_st", bs.EstPresente, 2'd0);
    check("t5_div0", bs.div0, 1'b0);
    @(negedge clk);
    check("t5_st_after", bs.EstPresente, 2'd0);
    run_s(32'd50, -16'sd5, 0, busy);
    check("t5b_busy", busy, 34);
    check("t5b_q", bs.quotient, 32'hFFFF_FFF6);
    check("t5b_r", bs.resto, 16'h0);

    // unsigned instance
    run_u(32'hFFFF_FFFF, 16'hFFFF, busy);
    check("t6_busy", busy, 34);
    check("t6_q", bu.quotient, 32'h0001_0001);
    check("t6_r", bu.resto, 16'h0);
    run_u(32'd10, 16'd4, busy);
    check("t6b_q", bu.quotient, 32'd2);
    check("t6b_r", bu.resto, exp_r(16'd2));
    run_u(32'hFFFF_FFFF, 16'd2, busy);
    check("t6c_q", bu.quotient, 32'h7FFF_FFFF);
    check("t6c_r", bu.resto, exp_r(16'd1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
